// File: rtl/ddr_axi_pkg.sv
// Shared AXI4 constants, write-master FSM encoding and a constant-friendly clog2
// used by the DDR3 MIG-facing AXI blocks.
`timescale 1ns/1ps
package ddr_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
    localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } wr_state_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axi_ddr_wr_master.sv
// AXI4 burst write master: one outstanding AW -> W -> B sequence per accepted
// wr_start, pulling upstream data one beat at a time through wr_req.
`timescale 1ns/1ps
module axi_ddr_wr_master
    import ddr_axi_pkg::*;
#(
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   wr_addr,
    input  logic [7:0]                      wr_len,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   wr_data,
    output logic                            wr_req,
    output logic                            wr_busy,
    output logic                            wr_done,
    output logic                            wr_err,
    output logic [C_M_AXI_ID_WIDTH-1:0]     m_axi_awid,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                      m_axi_awlen,
    output logic [2:0]                      m_axi_awsize,
    output logic [1:0]                      m_axi_awburst,
    output logic                            m_axi_awlock,
    output logic [3:0]                      m_axi_awcache,
    output logic [2:0]                      m_axi_awprot,
    output logic [3:0]                      m_axi_awqos,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wlast,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready
);

    localparam logic [2:0] AXI_SIZE = 3'(clog2(C_M_AXI_DATA_WIDTH / 8));

    wr_state_e                       state_reg, state_next;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_reg, awaddr_next;
    logic [7:0]                      awlen_reg, awlen_next;
    logic [7:0]                      beat_cnt_reg, beat_cnt_next;
    logic                            done_next, err_next;
    logic                            awvalid_reg, wvalid_reg, wlast_reg, bready_reg;
    logic                            busy_reg, done_reg, err_reg;
    logic                            w_hs;
    logic                            unused_bid;

    assign unused_bid = ^m_axi_bid;
    assign w_hs       = wvalid_reg & m_axi_wready;

    always_comb begin
        state_next    = state_reg;
        awaddr_next   = awaddr_reg;
        awlen_next    = awlen_reg;
        beat_cnt_next = beat_cnt_reg;
        done_next     = 1'b0;
        err_next      = err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (wr_start) begin
                    awaddr_next   = wr_addr;
                    // A zero length is treated as a single beat.
                    awlen_next    = (wr_len == 8'd0) ? 8'd0 : 8'(wr_len - 8'd1);
                    beat_cnt_next = 8'd0;
                    state_next    = ST_AW;
                end
            end
            ST_AW: begin
                if (m_axi_awready) state_next = ST_W;
            end
            ST_W: begin
                if (w_hs) begin
                    beat_cnt_next = 8'(beat_cnt_reg + 8'd1);
                    if (beat_cnt_reg == awlen_reg) state_next = ST_B;
                end
            end
            ST_B: begin
                if (m_axi_bvalid) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                    if (m_axi_bresp != AXI_RESP_OKAY) err_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake-facing outputs are registered from the next state so they
    // line up exactly with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            awaddr_reg   <= '0;
            awlen_reg    <= 8'd0;
            beat_cnt_reg <= 8'd0;
            awvalid_reg  <= 1'b0;
            wvalid_reg   <= 1'b0;
            wlast_reg    <= 1'b0;
            bready_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            awaddr_reg   <= awaddr_next;
            awlen_reg    <= awlen_next;
            beat_cnt_reg <= beat_cnt_next;
            awvalid_reg  <= (state_next == ST_AW);
            wvalid_reg   <= (state_next == ST_W);
            wlast_reg    <= (state_next == ST_W) && (beat_cnt_next == awlen_next);
            bready_reg   <= (state_next == ST_B);
            busy_reg     <= (state_next != ST_IDLE);
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    assign wr_req        = w_hs;
    assign wr_busy       = busy_reg;
    assign wr_done       = done_reg;
    assign wr_err        = err_reg;
    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = awaddr_reg;
    assign m_axi_awlen   = awlen_reg;
    assign m_axi_awsize  = AXI_SIZE;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = AXI_CACHE_DEFAULT;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;
    assign m_axi_awvalid = awvalid_reg;
    assign m_axi_wdata   = wr_data;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = wlast_reg;
    assign m_axi_wvalid  = wvalid_reg;
    assign m_axi_bready  = bready_reg;

endmodule

// File: tb/tb_axi_ddr_wr_master.sv
// Randomized bench for axi_ddr_wr_master: a reactive AXI slave plus a
// transaction-level model of the expected AW/W/B sequence and status outputs.
`timescale 1ns/1ps
module tb_axi_ddr_wr_master;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int IDW = 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_start = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [7:0]      wr_len = 8'd0;
    logic [DW-1:0]   wr_data;
    logic            wr_req, wr_busy, wr_done, wr_err;
    logic [IDW-1:0]  m_axi_awid;
    logic [AW-1:0]   m_axi_awaddr;
    logic [7:0]      m_axi_awlen;
    logic [2:0]      m_axi_awsize;
    logic [1:0]      m_axi_awburst;
    logic            m_axi_awlock;
    logic [3:0]      m_axi_awcache;
    logic [2:0]      m_axi_awprot;
    logic [3:0]      m_axi_awqos;
    logic            m_axi_awvalid, m_axi_awready;
    logic [DW-1:0]   m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic            m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [IDW-1:0]  m_axi_bid = '0;
    logic [1:0]      m_axi_bresp;
    logic            m_axi_bvalid, m_axi_bready;

    always #5 clk = ~clk;

    axi_ddr_wr_master #(
        .C_M_AXI_ID_WIDTH(IDW), .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_start(wr_start), .wr_addr(wr_addr), .wr_len(wr_len),
        .wr_data(wr_data), .wr_req(wr_req), .wr_busy(wr_busy), .wr_done(wr_done), .wr_err(wr_err),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [DW-1:0] pat(input int idx);
        return DW'(idx * 32'h9E3779B1) ^ 32'hA5A50000;
    endfunction

    // Stimulus knobs, written by the main sequence only.
    logic aw_hold = 1'b0, rand_ready = 1'b0, force_slverr = 1'b0, rand_resp = 1'b0;

    // Event counters written by the model, consumed by the slave.
    int req_cnt = 0, b_hs_cnt = 0, wlast_cnt = 0;

    // Reactive slave and upstream data source.
    int   b_seen = 0, wl_seen = 0;
    logic b_pend = 1'b0;
    initial begin
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        wr_data       = pat(0);
        forever begin
            @(posedge clk);
            #1;
            wr_data = pat(req_cnt);
            if (!rst_n) begin
                m_axi_bvalid = 1'b0;
                b_pend       = 1'b0;
                b_seen       = b_hs_cnt;
                wl_seen      = wlast_cnt;
            end else begin
                if (b_seen != b_hs_cnt) begin
                    b_seen       = b_hs_cnt;
                    m_axi_bvalid = 1'b0;
                end
                if (wl_seen != wlast_cnt) begin
                    wl_seen = wlast_cnt;
                    b_pend  = 1'b1;
                end
                if (b_pend && !m_axi_bvalid && (!rand_ready || $urandom_range(0, 2) == 0)) begin
                    m_axi_bvalid = 1'b1;
                    m_axi_bresp  = (force_slverr || (rand_resp && $urandom_range(0, 7) == 0)) ? 2'b10 : 2'b00;
                    b_pend       = 1'b0;
                end
            end
            m_axi_awready = aw_hold ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            m_axi_wready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Transaction model: phase 0 idle, 1 address, 2 data, 3 response.
    int            ph = 0, ph_nx, beat = 0, cur_len = 0;
    logic [AW-1:0] cur_addr = '0;
    logic          done_exp = 1'b0, err_mdl = 1'b0;
    logic [AW-1:0] acc_log[$];
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            ph       = 0;
            beat     = 0;
            done_exp = 1'b0;
            err_mdl  = 1'b0;
        end else begin
            check("busy",    wr_busy,       ph != 0);
            check("awvalid", m_axi_awvalid, ph == 1);
            check("wvalid",  m_axi_wvalid,  ph == 2);
            check("bready",  m_axi_bready,  ph == 3);
            check("done",    wr_done,       done_exp);
            check("err",     wr_err,        err_mdl);
            ph_nx    = ph;
            done_exp = 1'b0;
            case (ph)
                0: if (wr_start) begin
                    cur_addr = wr_addr;
                    cur_len  = (wr_len == 8'd0) ? 1 : int'(wr_len);
                    acc_log.push_back(wr_addr);
                    beat  = 0;
                    ph_nx = 1;
                end
                1: begin
                    check("awaddr", m_axi_awaddr, cur_addr);
                    check("awlen",  m_axi_awlen,  cur_len - 1);
                    if (m_axi_awready) begin
                        check("no_4k_cross", (int'(cur_addr[11:0]) + cur_len * 4) <= 4096, 1'b1);
                        ph_nx = 2;
                    end
                end
                2: begin
                    check("wr_req", wr_req,      m_axi_wready);
                    check("wlast",  m_axi_wlast, beat == cur_len - 1);
                    if (m_axi_wready) begin
                        check("wdata", m_axi_wdata, pat(req_cnt));
                        req_cnt++;
                        beat++;
                        if (beat == cur_len) begin
                            ph_nx = 3;
                            wlast_cnt++;
                        end
                    end
                end
                3: if (m_axi_bvalid) begin
                    check("beats", beat, cur_len);
                    if (m_axi_bresp != 2'b00) err_mdl = 1'b1;
                    done_exp = 1'b1;
                    ph_nx    = 0;
                    b_hs_cnt++;
                end
                default: ph_nx = 0;
            endcase
            ph = ph_nx;
        end
    end

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!wr_busy) break;
        end
        check("idle_wait", wr_busy, 1'b0);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (wr_done) break;
        end
        check("done_wait", wr_done, 1'b1);
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [7:0] l);
        wait_idle(2000);
        @(posedge clk);
        #1;
        wr_addr  = a;
        wr_len   = l;
        wr_start = 1'b1;
        @(posedge clk);
        #1;
        wr_start = 1'b0;
        $display("cmd addr=0x%0h len=%0d", a, l);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awvalid"}, m_axi_awvalid, 1'b0);
        check({tag, "_wvalid"},  m_axi_wvalid,  1'b0);
        check({tag, "_bready"},  m_axi_bready,  1'b0);
        check({tag, "_wr_req"},  wr_req,        1'b0);
        check({tag, "_busy"},    wr_busy,       1'b0);
        check({tag, "_done"},    wr_done,       1'b0);
        check({tag, "_err"},     wr_err,        1'b0);
        check({tag, "_awaddr"},  m_axi_awaddr,  32'h0);
        check({tag, "_awlen"},   m_axi_awlen,   8'h0);
    endtask

    int r0, a0, l, eff, off;
    initial begin
        #12;
        check_reset_outputs("rst");
        check("awsize",  m_axi_awsize,  3'd2);
        check("awburst", m_axi_awburst, 2'b01);
        check("awcache", m_axi_awcache, 4'b0011);
        check("wstrb",   m_axi_wstrb,   4'hF);
        check("awid",    m_axi_awid,    1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single beat, ready always high.
        r0 = req_cnt;
        send(32'h100, 8'd1);
        wait_done(50);
        check("t1_req", req_cnt - r0, 1);

        // 16 beats with randomly stalling readies.
        rand_ready = 1'b1;
        r0 = req_cnt;
        send(32'h2000, 8'd16);
        wait_done(1000);
        check("t2_req", req_cnt - r0, 16);

        // Address channel stalled for 20 cycles.
        rand_ready = 1'b0;
        aw_hold    = 1'b1;
        send(32'h3000, 8'd4);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t3_busy",   wr_busy,       1'b1);
            check("t3_wvalid", m_axi_wvalid,  1'b0);
            check("t3_awaddr", m_axi_awaddr,  32'h3000);
        end
        aw_hold = 1'b0;
        wait_done(100);

        // SLVERR sets a sticky error that survives later OKAY bursts.
        force_slverr = 1'b1;
        send(32'h4000, 8'd2);
        wait_done(100);
        force_slverr = 1'b0;
        check("t4_err", wr_err, 1'b1);
        for (int i = 0; i < 2; i++) begin
            send(32'h4100 + 32'(i * 64), 8'd3);
            wait_done(100);
            check("t4_err_sticky", wr_err, 1'b1);
        end

        // Back-to-back single-beat commands; wr_start stays high while busy.
        wait_idle(200);
        a0 = acc_log.size();
        r0 = req_cnt;
        @(posedge clk);
        #1;
        wr_len   = 8'd1;
        wr_start = 1'b1;
        for (int n = 0; n < 8; n++) begin
            wr_addr = 32'h5000 + 32'(4 * n);
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (m_axi_awvalid) break;
            end
            check("t5_aw_seen", m_axi_awvalid, 1'b1);
            @(posedge clk);
            #1;
        end
        wr_start = 1'b0;
        wait_done(100);
        check("t5_count", acc_log.size() - a0, 8);
        check("t5_req",   req_cnt - r0, 8);
        for (int n = 0; n < 8 && a0 + n < acc_log.size(); n++)
            check("t5_addr", acc_log[a0 + n], 32'h5000 + 32'(4 * n));

        // Reset while beat 3 of 8 is on the bus.
        send(32'h6000, 8'd8);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m_axi_wvalid) break;
        end
        check("t6_wvalid", m_axi_wvalid, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("t6");
        check("t6_wlast", m_axi_wlast, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        r0 = req_cnt;
        send(32'h6100, 8'd3);
        wait_done(100);
        check("t6_req", req_cnt - r0, 3);

        // Random bursts, random readiness and occasional error responses.
        rand_ready = 1'b1;
        rand_resp  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            l   = $urandom_range(0, 24);
            eff = (l == 0) ? 1 : l;
            off = 4 * $urandom_range(0, 1024 - eff);
            r0  = req_cnt;
            send({20'($urandom_range(0, 1023)), 12'(off)}, 8'(l));
            wait_done(2000);
            check("rnd_req", req_cnt - r0, eff);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
